// File: rtl/tcp_bus_pkg.sv
// Shared types for the tcpBus arbiter: FSM states and downstream response codes.
package tcp_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        WRSP,
        RDATA
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, as one-hot and index.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] index,
    output logic                     any
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CW    = IDX_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            // Wrap ptr+i back into 0..N_REQ-1 without a modulo operator.
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any   = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
        if (any) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/tcp_bus_arbiter.sv
// Round-robin arbiter sharing one tcpBus command/data/response port between N_REQ requesters.
// Define TCP_ARB_STATS_EN to add per-requester completed-transaction counters (stat_count).
module tcp_bus_arbiter
    import tcp_bus_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         s_cmd_valid,
    output logic [N_REQ-1:0]         s_cmd_ready,
    input  logic [N_REQ-1:0]         s_cmd_write,
    input  logic [N_REQ*ADDR_W-1:0]  s_cmd_addr,
    input  logic [N_REQ*32-1:0]      s_cmd_size,
    input  logic [N_REQ-1:0]         s_wdata_valid,
    output logic [N_REQ-1:0]         s_wdata_ready,
    input  logic [N_REQ-1:0]         s_wdata_last,
    input  logic [N_REQ*DATA_W-1:0]  s_wdata_data,
    output logic [N_REQ-1:0]         s_rdata_valid,
    input  logic [N_REQ-1:0]         s_rdata_ready,
    output logic                     s_rdata_last,
    output logic [DATA_W-1:0]        s_rdata_data,
    output logic [N_REQ-1:0]         s_rsp_valid,
    output logic [1:0]               s_rsp_resp,
    output logic                     m_cmd_valid,
    input  logic                     m_cmd_ready,
    output logic                     m_cmd_write,
    output logic [ADDR_W-1:0]        m_cmd_addr,
    output logic [31:0]              m_cmd_size,
    output logic                     m_wdata_valid,
    input  logic                     m_wdata_ready,
    output logic                     m_wdata_last,
    output logic [DATA_W-1:0]        m_wdata_data,
    input  logic                     m_rdata_valid,
    output logic                     m_rdata_ready,
    input  logic                     m_rdata_last,
    input  logic [DATA_W-1:0]        m_rdata_data,
    input  logic                     m_rsp_valid,
    input  logic [1:0]               m_rsp_resp
`ifdef TCP_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   stat_count
`endif
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || CNT_W < 1) begin : g_bad_params
        $error("tcp_bus_arbiter: unsupported parameters");
    end

    arb_state_e       state_q;
    logic [IDX_W-1:0] gnt_q, ptr_q, next_ptr, arb_index;
    logic             write_q, rsp_flag_q;
    logic [1:0]       rsp_code_q;
    logic [N_REQ-1:0] arb_grant;
    logic             arb_any, arb_write;
    logic             wr_last_fire, rsp_fire, txn_done;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req   (s_cmd_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    assign arb_write = |(s_cmd_write & arb_grant);
    assign next_ptr  = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            write_q    <= 1'b0;
            rsp_flag_q <= 1'b0;
            rsp_code_q <= RESP_OKAY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q      <= arb_index;
                        write_q    <= arb_write;
                        rsp_flag_q <= 1'b0;
                        state_q    <= CMD;
                    end
                end
                CMD: begin
                    if (m_cmd_ready) begin
                        state_q <= write_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    // A response can overtake the last beat; hold it until WRSP.
                    if (m_rsp_valid) begin
                        rsp_flag_q <= 1'b1;
                        rsp_code_q <= m_rsp_resp;
                    end
                    if (wr_last_fire) begin
                        state_q <= WRSP;
                    end
                end
                WRSP, RDATA: begin
                    if (txn_done) begin
                        state_q <= IDLE;
                        ptr_q   <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_cmd_ready   = '0;
        s_wdata_ready = '0;
        s_rdata_valid = '0;
        s_rsp_valid   = '0;
        s_rsp_resp    = RESP_OKAY;
        s_rdata_last  = 1'b0;
        s_rdata_data  = '0;
        m_cmd_valid   = 1'b0;
        m_cmd_write   = 1'b0;
        m_cmd_addr    = '0;
        m_cmd_size    = '0;
        m_wdata_valid = 1'b0;
        m_wdata_last  = 1'b0;
        m_wdata_data  = '0;
        m_rdata_ready = 1'b0;
        wr_last_fire  = 1'b0;
        rsp_fire      = 1'b0;
        txn_done      = 1'b0;
        unique case (state_q)
            CMD: begin
                m_cmd_valid        = 1'b1;
                m_cmd_write        = write_q;
                m_cmd_addr         = s_cmd_addr[gnt_q*ADDR_W +: ADDR_W];
                m_cmd_size         = s_cmd_size[gnt_q*32 +: 32];
                s_cmd_ready[gnt_q] = m_cmd_ready;
            end
            WDATA: begin
                m_wdata_valid        = s_wdata_valid[gnt_q];
                m_wdata_last         = s_wdata_last[gnt_q];
                m_wdata_data         = s_wdata_data[gnt_q*DATA_W +: DATA_W];
                s_wdata_ready[gnt_q] = m_wdata_ready;
                wr_last_fire         = m_wdata_valid & m_wdata_ready & m_wdata_last;
            end
            WRSP: begin
                rsp_fire           = m_rsp_valid | rsp_flag_q;
                s_rsp_valid[gnt_q] = rsp_fire;
                s_rsp_resp         = rsp_flag_q ? rsp_code_q : m_rsp_resp;
                txn_done           = rsp_fire;
            end
            RDATA: begin
                s_rdata_valid[gnt_q] = m_rdata_valid;
                m_rdata_ready        = s_rdata_ready[gnt_q];
                s_rdata_last         = m_rdata_last;
                s_rdata_data         = m_rdata_data;
                txn_done             = m_rdata_valid & m_rdata_ready & m_rdata_last;
            end
            default: ;
        endcase
    end

`ifdef TCP_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (txn_done && (cnt_q[gnt_q] != '1)) begin
            cnt_q[gnt_q] <= cnt_q[gnt_q] + CNT_W'(1);
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            stat_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && (state_q == IDLE) && (m_rdata_valid || m_rsp_valid)) begin
            $error("tcp_bus_arbiter: downstream rdata/rsp valid while idle");
        end
    end
`endif

endmodule
